// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN (adds trailing XOR checksum byte).
package imem_loader_pkg;

    localparam int unsigned HDR_LEN        = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8->32 big-endian byte packer: first byte of a group lands in word[31:24].
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              last_byte_c
);

    localparam int unsigned SHIFT_W = WORD_W - 8;

    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  word_valid_q, word_valid_d;

    assign last_byte_c = (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign word        = word_q;
    assign word_valid  = word_valid_q;

    // Shift bytes in; on the last byte of a group publish the word for one cycle.
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_en) begin
            if (last_byte_c) begin
                word_d       = {shift_q, byte_in};
                word_valid_d = 1'b1;
                cnt_d        = '0;
            end else begin
                shift_d = {shift_q[SHIFT_W-9:0], byte_in};
                cnt_d   = cnt_q + BYTE_CNT_W'(1);
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM writer: parses N-word header, streams big-endian
// words into RAM, holds the core in reset until the image is complete.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                reload,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                cpu_rst,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     words_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e ST_FINISH = ST_CSUM;
`else
    localparam state_e ST_FINISH = ST_DONE;
`endif

    state_e              state_q, state_d;
    logic [7:0]          n_hi_q, n_hi_d;
    logic [CNT_W-1:0]    n_words_q, n_words_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                in_ready_q, in_ready_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                accept_c;
    logic                restart_c;
    logic                pack_en_c;
    logic                last_byte_c;
    logic [15:0]         hdr_n_c;
    logic                pk_valid;
    logic [WORD_W-1:0]   pk_word;

    assign accept_c  = in_valid && in_ready_q;
    assign restart_c = reload && ((state_q == ST_DONE) || (state_q == ST_ERR));
    assign pack_en_c = accept_c && (state_q == ST_DATA);
    assign hdr_n_c   = {n_hi_q, in_data};

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (restart_c),
        .byte_en     (pack_en_c),
        .byte_in     (in_data),
        .word        (pk_word),
        .word_valid  (pk_valid),
        .last_byte_c (last_byte_c)
    );

    assign in_ready     = in_ready_q;
    assign mem_we       = pk_valid;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = pk_word;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

    // Next-state, counters and registered status outputs.
    always_comb begin
        state_d   = state_q;
        n_hi_d    = n_hi_q;
        n_words_d = n_words_q;
        words_d   = words_q;
        waddr_d   = waddr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = accept_c ? (csum_q ^ in_data) : csum_q;
`endif

        case (state_q)
            ST_HDR_HI: begin
                if (accept_c) begin
                    n_hi_d  = in_data;
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept_c) begin
                    if (hdr_n_c == 16'd0) begin
                        state_d = ST_FINISH;
                    end else if (32'(hdr_n_c) > DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        n_words_d = CNT_W'(hdr_n_c);
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept_c && last_byte_c) begin
                    waddr_d = words_q[ADDR_W-1:0];
                    words_d = words_q + CNT_W'(1);
                    if (words_d == n_words_q) begin
                        state_d = ST_FINISH;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_c) begin
                    state_d = (csum_d == 8'h00) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (restart_c) begin
                    state_d = ST_HDR_HI;
                    words_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            default: state_d = ST_ERR;
        endcase

        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        in_ready_d = !((state_d == ST_DONE) || (state_d == ST_ERR));
        // Core leaves reset one cycle after DONE is entered; reload re-asserts it.
        cpu_rst_d  = !((state_q == ST_DONE) && !restart_c);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HDR_HI;
            n_hi_q     <= '0;
            n_words_q  <= '0;
            words_q    <= '0;
            waddr_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            n_hi_q     <= n_hi_d;
            n_words_q  <= n_words_d;
            words_q    <= words_d;
            waddr_q    <= waddr_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (both checksum build variants).
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write log captured mid-cycle.
    logic [ADDR_W-1:0] addr_log [64];
    logic [31:0]       data_log [64];
    int                cyc_log  [64];
    int                wr_total = 0;
    int                cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (mem_we && wr_total < 64) begin
            addr_log[wr_total] = mem_waddr;
            data_log[wr_total] = mem_wdata;
            cyc_log[wr_total]  = cyc;
            wr_total++;
        end
    end

    logic [7:0] stream [$];
    int         base;

    // Append the checksum byte in the checksum build.
    task automatic seal();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        stream.push_back(x);
`endif
    endtask

    // Drive the stream; returns at the negedge after the last handshake, in_valid low.
    task automatic send_stream(input bit gap);
        foreach (stream[i]) begin
            if (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = stream[i];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        reload   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_loaded, 0);
        rst = 1'b0;

        // Two words, in_valid held.
        base   = wr_total;
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
        seal();
        send_stream(1'b0);
        check("t1_done", done, 1);
        check("t1_cpu_rst_hold", cpu_rst, 1);
        check("t1_words", words_loaded, 2);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("t1_last_we", mem_we, 1);
        check("t1_last_addr", mem_waddr, 1);
`endif
        @(negedge clk);
        check("t1_cpu_rst_fall", cpu_rst, 0);
        check("t1_in_ready", in_ready, 0);
        check("t1_we_idle", mem_we, 0);
        settle();
        check("t1_wr_count", wr_total - base, 2);
        check("t1_addr0", addr_log[base], 0);
        check("t1_data0", data_log[base], 32'h20080005);
        check("t1_addr1", addr_log[base+1], 1);
        check("t1_data1", data_log[base+1], 32'hAC080004);
        check("t1_spacing", cyc_log[base+1] - cyc_log[base], 4);

        // Same stream with gaps between bytes.
        do_reset();
        check("t2_rst_cpu_rst", cpu_rst, 1);
        check("t2_rst_done", done, 0);
        check("t2_rst_words", words_loaded, 0);
        base   = wr_total;
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
        seal();
        send_stream(1'b1);
        check("t2_done", done, 1);
        settle();
        check("t2_wr_count", wr_total - base, 2);
        check("t2_data0", data_log[base], 32'h20080005);
        check("t2_data1", data_log[base+1], 32'hAC080004);

        // Oversized header aborts with no writes.
        do_reset();
        base   = wr_total;
        stream = '{8'h01, 8'h01};
        send_stream(1'b0);
        check("t3_err", err, 1);
        check("t3_in_ready", in_ready, 0);
        check("t3_cpu_rst", cpu_rst, 1);
        check("t3_done", done, 0);
        stream = '{8'h20, 8'h08, 8'h00, 8'h05};
        send_stream(1'b0);
        settle();
        check("t3_wr_count", wr_total - base, 0);
        check("t3_err_hold", err, 1);
        check("t3_words", words_loaded, 0);

        // Empty image completes without writes.
        do_reset();
        base   = wr_total;
        stream = '{8'h00, 8'h00};
        seal();
        send_stream(1'b0);
        check("t3b_done", done, 1);
        settle();
        check("t3b_wr_count", wr_total - base, 0);
        check("t3b_cpu_rst", cpu_rst, 0);

        // Reset after six data bytes, then a fresh one-word image.
        do_reset();
        base   = wr_total;
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08};
        send_stream(1'b0);
        do_reset();
        check("t4_rst_words", words_loaded, 0);
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        seal();
        send_stream(1'b0);
        check("t4_done", done, 1);
        check("t4_words", words_loaded, 1);
        settle();
        check("t4_wr_count", wr_total - base, 2);
        check("t4_addr", addr_log[base+1], 0);
        check("t4_data", data_log[base+1], 32'h12345678);

        // Reload from DONE and load a new image.
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("t5_cpu_rst", cpu_rst, 1);
        check("t5_done_clr", done, 0);
        check("t5_words_clr", words_loaded, 0);
        check("t5_in_ready", in_ready, 1);
        base   = wr_total;
        stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        seal();
        send_stream(1'b0);
        check("t5_done", done, 1);
        check("t5_words", words_loaded, 1);
        check("t5_waddr", mem_waddr, 0);
        check("t5_wdata", mem_wdata, 32'hCAFEBABE);
        settle();
        check("t5_wr_count", wr_total - base, 1);
        check("t5_cpu_rst_low", cpu_rst, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Correct and wrong checksum bytes.
        do_reset();
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_stream(1'b0);
        check("t6_ok_done", done, 1);
        check("t6_ok_err", err, 0);
        do_reset();
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        send_stream(1'b0);
        check("t6_bad_err", err, 1);
        check("t6_bad_done", done, 0);
        check("t6_bad_words", words_loaded, 1);
        check("t6_bad_cpu_rst", cpu_rst, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
